compl_acc_dump: RTL
===================

Name: compl_acc_dump

Overview:
Integrate-and-dump stage directly downstream of compl_mul. It accumulates a programmable number of 37-bit complex products, then emits the frame sum. The sum is scaled by a programmable right shift, rounded, and saturated to 18-bit I/Q, which is the input width of the multiplier. It closes the multiply-accumulate path, for example for correlation against a reference sequence, and feeds results back into the 18-bit datapath.

Parameters:
IN_W, 37, width of signed input I/Q (compl_mul output width)
LEN_W, 16, width of frame-length input
ACC_W, 53, accumulator width; IN_W+LEN_W, so no internal overflow at any legal length
OUT_W, 18, width of signed output I/Q

Ports:
clk_i  in  1  clock
arst_i  in  1  reset
data_i_i  in  IN_W  signed input real part
data_q_i  in  IN_W  signed input imaginary part
data_valid_i  in  1  input sample valid
len_i  in  LEN_W  samples per frame; 0 treated as 1
shift_i  in  6  output right-shift; values >= ACC_W clamp to ACC_W-1
clr_i  in  1  synchronous discard of the partial frame
data_i_o  out  OUT_W  signed rounded/saturated real sum
data_q_o  out  OUT_W  signed rounded/saturated imaginary sum
data_valid_o  out  1  one-cycle result strobe
sat_o  out  1  I or Q saturated; qualified by data_valid_o
busy_o  out  1  a frame is partially accumulated

Behaviour:
- Clock and reset: single clock clk_i; reset arst_i is asynchronous, active-high.
- Reset values: all outputs 0, accumulators 0, count 0, state IDLE.
- Reset mid-frame: the partial frame and any pending dump are lost. The first valid sample after release starts a new frame.
- Input timing: no backpressure. A sample is accepted in every cycle where data_valid_i=1. Gaps in valid are allowed and do not advance the count.
- IDLE:
  - On a valid sample, latch len_i (0→1) and shift_i into frame registers.
  - Load the accumulator with the sample (not added to the old value) and set count=1.
  - If latched len=1, dump immediately. Otherwise go to ACC.
- ACC:
  - Each valid sample: acc+=sample (sign-extended to ACC_W), count++.
  - On the sample where count reaches len, dump.
- Dump:
  - On the edge accepting the final sample, write acc+sample to the dump register with its shift, and return to IDLE.
  - A valid sample in the very next cycle starts a new frame without loss, so back-to-back frames have no gap.
- Output stage: one register after the dump register.
  - Latency: data_valid_o is high for exactly one cycle, 2 cycles after the cycle carrying the frame's last sample.
  - data_i_o, data_q_o and sat_o hold their value until the next strobe.
- len_i and shift_i changes mid-frame are ignored until the next frame start.
- busy_o = state ACC.
- clr_i:
  - Returns to IDLE and zeroes the accumulator and count.
  - Does not cancel a dump already in the output pipeline.
  - If clr_i and data_valid_i are high in the same cycle, the sample becomes the first sample of a new frame.
- Arithmetic (per rail):
  - If s>0, r=(sum + 2^(s-1)) >>> s (round half up, arithmetic shift). If s=0, r=sum.
  - Pre-add computed at ACC_W+1 bits, so there is no wrap.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - sat_o = sat_I | sat_Q.

Decomposition:
- Package compl_pkg holds:
  - constants IN_W=37, OUT_W=18, LEN_W=16, ACC_W=53;
  - typedef struct for complex sample {logic signed [IN_W-1:0] i, q};
  - enum for state {IDLE, ACC}.
- Sub-module compl_round_sat: combinational round-shift-saturate for one rail (params ACC_W, OUT_W), instantiated twice for I and Q. It outputs the value and a saturation flag.

Test Plan:
1. len=1, shift=0, single sample (23,-2) → data_valid_o pulses 2 cycles later with (23,-2), sat_o=0, busy_o never high.
2. len=4, shift=2, samples (1,0),(0,2),(23,-2),(-4,4) with one idle cycle between the 2nd and 3rd → one strobe with (5,1). len=2, shift=1, samples (3,-3),(0,0) → (2,-1), checking round half up.
3. len=1, shift=0, input (2^35, -2^35) → (131071, -131072), sat_o=1. Next frame (5,5) → (5,5), sat_o=0.
4. len=2, shift=0, continuous valid for 8 samples (k,-k), k=1..8 → 4 strobes every 2 cycles: (3,-3),(7,-7),(11,-11),(15,-15). No dropped samples.
5. len=4, shift=0: 2 samples of (9,9), then clr_i together with valid (1,1), then 3 more (1,1) → single strobe (4,4). Also check that len_i changed mid-frame has no effect.
6. Assert arst_i asynchronously mid-frame (between edges) → outputs and busy_o go 0 immediately without a clock edge. After release, len=1 sample (7,0) → (7,0).

Source files
------------

// File: rtl/compl_acc_dump_pkg.sv
// Shared constants, complex sample types and FSM state for the integrate-and-dump stage.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
//
// Contents: widths, complex sample / accumulator structs, state enum,
// frame-length and shift normalisation helpers.
package compl_pkg;

  localparam int IN_W    = 37;            // compl_mul output width
  localparam int OUT_W   = 18;            // multiplier input width
  localparam int LEN_W   = 16;            // frame-length field width
  localparam int ACC_W   = IN_W + LEN_W;  // holds 2^LEN_W-1 full-scale samples
  localparam int SHIFT_W = 6;             // output shift field width

  // One complex product as delivered by compl_mul.
  typedef struct packed {
    logic signed [IN_W-1:0] i;
    logic signed [IN_W-1:0] q;
  } cplx_t;

  // Accumulator-width complex value (running sum and dumped frame sum).
  typedef struct packed {
    logic signed [ACC_W-1:0] i;
    logic signed [ACC_W-1:0] q;
  } cplx_acc_t;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  // A zero length would never terminate a frame; it is treated as one sample.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    return (len == '0) ? LEN_W'(1) : len;
  endfunction

  // Shifting by ACC_W or more would discard the whole sum including its sign;
  // cap at ACC_W-1 so the result is still the rounded sign-correct quotient.
  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s >= SHIFT_W'(ACC_W)) ? SHIFT_W'(ACC_W - 1) : s;
  endfunction

endpackage

// File: rtl/compl_acc_dump_if.sv
// Bus bundle between the sample source/result sink and compl_acc_dump.
// Latency: n/a (wiring only).
// Backpressure: none; samples are accepted whenever data_valid_i is high.
//
// master: drives samples, frame controls and clear; observes results.
// slave : the accumulator; consumes samples, drives results and busy.
interface compl_acc_dump_if;
  import compl_pkg::*;

  // sample input side
  logic signed [IN_W-1:0]  data_i_i;
  logic signed [IN_W-1:0]  data_q_i;
  logic                    data_valid_i;
  logic [LEN_W-1:0]        len_i;
  logic [SHIFT_W-1:0]      shift_i;
  logic                    clr_i;

  // result side
  logic signed [OUT_W-1:0] data_i_o;
  logic signed [OUT_W-1:0] data_q_o;
  logic                    data_valid_o;
  logic                    sat_o;
  logic                    busy_o;

  modport master (
    output data_i_i, data_q_i, data_valid_i, len_i, shift_i, clr_i,
    input  data_i_o, data_q_o, data_valid_o, sat_o, busy_o
  );

  modport slave (
    input  data_i_i, data_q_i, data_valid_i, len_i, shift_i, clr_i,
    output data_i_o, data_q_o, data_valid_o, sat_o, busy_o
  );

endinterface

// File: rtl/compl_acc_dump_round_sat.sv
// One rail of round-half-up arithmetic right shift followed by saturation to OUT_W.
// Latency: combinational.
// Backpressure: n/a.
//
// Ports: sum_i (signed ACC_W), shift_i (SHIFT_W) in; val_o (signed OUT_W), sat_o out.
module compl_round_sat #(
  parameter int ACC_W   = 53,
  parameter int OUT_W   = 18,
  parameter int SHIFT_W = 6
) (
  input  logic signed [ACC_W-1:0] sum_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  output logic signed [OUT_W-1:0] val_o,
  output logic                    sat_o
);

  // Rounding is done one bit wider than the sum so adding the half-LSB bias
  // to a near-full-scale positive sum cannot wrap negative.
  localparam logic signed [ACC_W:0] SAT_MAX =
    $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] bias;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] shr;
  logic signed [ACC_W:0] clip;
  logic                  unused_hi;

  always_comb begin
    ext  = {sum_i[ACC_W-1], sum_i};
    bias = '0;
    if (shift_i != '0) begin
      bias = {{ACC_W{1'b0}}, 1'b1} << (shift_i - SHIFT_W'(1));
    end
    rnd = ext + bias;
    // >>> on a signed operand floors toward -inf, so +half then floor is round half up.
    shr = rnd >>> shift_i;
  end

  always_comb begin
    clip  = shr;
    sat_o = 1'b0;
    if (shr > SAT_MAX) begin
      clip  = SAT_MAX;
      sat_o = 1'b1;
    end else if (shr < SAT_MIN) begin
      clip  = SAT_MIN;
      sat_o = 1'b1;
    end
  end

  // After clipping the upper bits are pure sign extension.
  assign val_o     = clip[OUT_W-1:0];
  assign unused_hi = ^clip[ACC_W:OUT_W];

endmodule

// File: rtl/compl_acc_dump.sv
// Integrate-and-dump of complex products: sums len samples, then emits the
// shifted, rounded, saturated frame sum. Latency: result strobe 2 cycles after
// the frame's last sample. Backpressure: none; every valid sample is consumed.
//
// Ports: clk_i, arst_i (async, active-high); bus (compl_acc_dump_if.slave):
//   data_i_i/data_q_i/data_valid_i samples, len_i/shift_i latched at frame start,
//   clr_i discards the partial frame; data_i_o/data_q_o/sat_o held between
//   data_valid_o strobes; busy_o while a frame is partially accumulated.
module compl_acc_dump
  import compl_pkg::*;
(
  input  logic              clk_i,
  input  logic              arst_i,
  compl_acc_dump_if.slave   bus
);

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e             state_q;
  state_e             state_d;

  // FSM output decode
  logic               frame_start;  // this sample opens a new frame
  logic               busy;

  cplx_t              samp;
  cplx_acc_t          acc_q;
  cplx_acc_t          base;
  cplx_acc_t          sum;
  logic [LEN_W-1:0]   cnt_q;
  logic [LEN_W-1:0]   cnt_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_cur;
  logic [SHIFT_W-1:0] shift_q;
  logic [SHIFT_W-1:0] shift_cur;
  logic               last;         // this sample completes the frame

  // dump register
  logic               dump_vld_q;
  cplx_acc_t          dump_q;
  logic [SHIFT_W-1:0] dump_shift_q;

  // round/saturate results
  logic signed [OUT_W-1:0] rs_i_val;
  logic signed [OUT_W-1:0] rs_q_val;
  logic                    rs_i_sat;
  logic                    rs_q_sat;

  assign samp.i = bus.data_i_i;
  assign samp.q = bus.data_q_i;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // A valid sample always wins over clr_i: with both high the sample opens a
  // fresh frame, which may itself be a complete one-sample frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (bus.data_valid_i) begin
      state_d = last ? IDLE : ACC;
    end else if (bus.clr_i) begin
      state_d = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy        = (state_q == ACC);
    frame_start = bus.data_valid_i && ((state_q == IDLE) || bus.clr_i);
  end

  assign bus.busy_o = busy;

  // ---------------------------------------------------------------------------
  // Accumulate datapath
  // At frame start the sample is loaded rather than added, so a cleared or
  // completed frame never leaks into the next one.
  // ---------------------------------------------------------------------------
  always_comb begin
    len_cur   = frame_start ? eff_len(bus.len_i) : len_q;
    shift_cur = frame_start ? clamp_shift(bus.shift_i) : shift_q;
    base      = frame_start ? '0 : acc_q;
    sum.i     = base.i + {{(ACC_W - IN_W){samp.i[IN_W-1]}}, samp.i};
    sum.q     = base.q + {{(ACC_W - IN_W){samp.q[IN_W-1]}}, samp.q};
    cnt_nxt   = frame_start ? LEN_W'(1) : (cnt_q + LEN_W'(1));
    last      = bus.data_valid_i && (cnt_nxt == len_cur);
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= LEN_W'(1);
      shift_q <= '0;
    end else begin
      if (bus.data_valid_i) begin
        if (last) begin
          acc_q <= '0;
          cnt_q <= '0;
        end else begin
          acc_q <= sum;
          cnt_q <= cnt_nxt;
        end
      end else if (bus.clr_i) begin
        acc_q <= '0;
        cnt_q <= '0;
      end
      if (frame_start) begin
        len_q   <= len_cur;
        shift_q <= shift_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dump register: captures the completed sum together with its frame's shift
  // so the next frame can start on the very next cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      dump_vld_q   <= 1'b0;
      dump_q       <= '0;
      dump_shift_q <= '0;
    end else begin
      dump_vld_q <= last;
      if (last) begin
        dump_q       <= sum;
        dump_shift_q <= shift_cur;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
  compl_round_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_rs_i (
    .sum_i   (dump_q.i),
    .shift_i (dump_shift_q),
    .val_o   (rs_i_val),
    .sat_o   (rs_i_sat)
  );

  compl_round_sat #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (SHIFT_W)
  ) u_rs_q (
    .sum_i   (dump_q.q),
    .shift_i (dump_shift_q),
    .val_o   (rs_q_val),
    .sat_o   (rs_q_sat)
  );

  // Data and sat hold between strobes; only the strobe itself is a pulse.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      bus.data_valid_o <= 1'b0;
      bus.data_i_o     <= '0;
      bus.data_q_o     <= '0;
      bus.sat_o        <= 1'b0;
    end else begin
      bus.data_valid_o <= dump_vld_q;
      if (dump_vld_q) begin
        bus.data_i_o <= rs_i_val;
        bus.data_q_o <= rs_q_val;
        bus.sat_o    <= rs_i_sat | rs_q_sat;
      end
    end
  end

endmodule
